// File: rtl/shift_out_ctrl.sv
// Serial frame shifter for a 3-wire chain of external shift registers
// (s_clk / s_dat / s_latch). A parallel frame is captured on start, sent
// byte 0 first and LSB first within each byte, then latched with a strobe
// and completion is reported with a one-cycle done pulse.
module shift_out_ctrl #(
  parameter int NBYTES  = 4,
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [8*NBYTES-1:0]   frame,
  output logic                  busy,
  output logic                  done,
  output logic                  s_clk,
  output logic                  s_dat,
  output logic                  s_latch
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOW,
    S_HIGH,
    S_LATCH,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [8*NBYTES-1:0]   buf_q, buf_d;
  logic [7:0]            sr_q, sr_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;

  logic busy_q, done_q, s_clk_q, s_dat_q, s_latch_q;
  logic busy_d, done_d, s_clk_d, s_dat_d, s_latch_d;

  // Select one byte of the captured frame by index.
  function automatic logic [7:0] byte_of(input logic [8*NBYTES-1:0] b,
                                         input logic [IDX_W-1:0]    idx);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDX_W'(i)) r = b[8*i +: 8];
    end
    return r;
  endfunction

  // State, frame buffer, shift register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      div_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

  // Next-state logic: phase timing, bit/byte sequencing and abort handling.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    div_cnt_d  = div_cnt_q;

    case (state_q)
      S_IDLE: begin
        // abort outranks a simultaneous start
        if (start && !abort) begin
          buf_d   = frame;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (abort) begin
          sr_d    = '0;
          state_d = S_IDLE;
        end else begin
          sr_d       = byte_of(buf_q, '0);
          bit_cnt_d  = '0;
          byte_idx_d = '0;
          div_cnt_d  = '0;
          state_d    = S_LOW;
        end
      end

      S_LOW: begin
        if (abort) begin
          sr_d    = '0;
          state_d = S_IDLE;
        end else if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          state_d   = S_HIGH;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      S_HIGH: begin
        if (abort) begin
          sr_d    = '0;
          state_d = S_IDLE;
        end else if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q != 3'd7) begin
            sr_d      = {1'b0, sr_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = S_LOW;
          end else if (byte_idx_q != IDX_LAST) begin
            // next byte is loaded straight away, no gap cycle
            sr_d       = byte_of(buf_q, byte_idx_q + 1'b1);
            bit_cnt_d  = '0;
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = S_LOW;
          end else begin
            state_d = S_LATCH;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      S_LATCH: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          state_d   = S_DONE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the pins leave flops glitch-free.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    s_clk_d   = (state_d == S_HIGH);
    s_latch_d = (state_d == S_LATCH);
    s_dat_d   = ((state_d == S_LOW) || (state_d == S_HIGH)) ? sr_d[0] : 1'b0;
  end

  // Registered outputs toward the external chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_clk_q   <= 1'b0;
      s_dat_q   <= 1'b0;
      s_latch_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_clk_q   <= s_clk_d;
      s_dat_q   <= s_dat_d;
      s_latch_q <= s_latch_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign s_clk   = s_clk_q;
  assign s_dat   = s_dat_q;
  assign s_latch = s_latch_q;

endmodule

// File: tb/tb_shift_out_ctrl.sv
// Bench for shift_out_ctrl: a default instance (4 bytes, divide by 2) and a
// minimal instance (1 byte, divide by 1), each checked every cycle against
// a timeline model, plus directed scenarios with literal expectations.
module tb_shift_out_ctrl;

  localparam int NA = 4;
  localparam int DA = 2;
  localparam int NB = 1;
  localparam int DB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, abort_a, start_b, abort_b;
  logic [31:0] frame_a;
  logic [7:0]  frame_b;
  logic busy_a, done_a, s_clk_a, s_dat_a, s_latch_a;
  logic busy_b, done_b, s_clk_b, s_dat_b, s_latch_b;

  shift_out_ctrl #(.NBYTES(NA), .CLK_DIV(DA)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .frame(frame_a), .busy(busy_a), .done(done_a), .s_clk(s_clk_a),
    .s_dat(s_dat_a), .s_latch(s_latch_a)
  );

  shift_out_ctrl #(.NBYTES(NB), .CLK_DIV(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .frame(frame_b), .busy(busy_b), .done(done_b), .s_clk(s_clk_b),
    .s_dat(s_dat_b), .s_latch(s_latch_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // t = cycles since the accept edge (0 = idle). t=1 load, then 16*n*d
  // cycles of serial bits (each bit: d low then d high), d latch cycles,
  // then one done cycle.
  function automatic int len_f(input int n, input int d);
    return 2 + 16*n*d + d;
  endfunction

  // returns {busy, done, s_clk, s_dat, s_latch}
  function automatic logic [4:0] exp_f(input int t, input int n, input int d,
                                       input logic [31:0] fr);
    logic [4:0] e;
    int k;
    e = '0;
    if (t == 0) return e;
    e[4] = 1'b1;
    if (t >= 2 && t <= 1 + 16*n*d) begin
      k    = t - 2;
      e[2] = ((k % (2*d)) >= d);
      e[1] = fr[k / (2*d)];
    end
    if (t >= 2 + 16*n*d && t <= 1 + 16*n*d + d) e[0] = 1'b1;
    if (t == len_f(n, d)) e[3] = 1'b1;
    return e;
  endfunction

  function automatic int next_t(input int t, input int n, input int d,
                                input logic st, input logic ab);
    if (t == 0) return (st && !ab) ? 1 : 0;
    if (ab && t <= 1 + 16*n*d) return 0;
    if (t == len_f(n, d)) return 0;
    return t + 1;
  endfunction

  int          t_a = 0;
  int          t_b = 0;
  logic [31:0] fr_a = '0;
  logic [31:0] fr_b = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_a = 0;
      t_b = 0;
    end else begin
      if (t_a == 0 && start_a && !abort_a) fr_a = frame_a;
      if (t_b == 0 && start_b && !abort_b) fr_b = {24'b0, frame_b};
      t_a = next_t(t_a, NA, DA, start_a, abort_a);
      t_b = next_t(t_b, NB, DB, start_b, abort_b);
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    logic [4:0] ea, eb;
    ea = exp_f(t_a, NA, DA, fr_a);
    eb = exp_f(t_b, NB, DB, fr_b);
    chk("a_busy",    int'(busy_a),    int'(ea[4]));
    chk("a_done",    int'(done_a),    int'(ea[3]));
    chk("a_s_clk",   int'(s_clk_a),   int'(ea[2]));
    chk("a_s_dat",   int'(s_dat_a),   int'(ea[1]));
    chk("a_s_latch", int'(s_latch_a), int'(ea[0]));
    chk("b_busy",    int'(busy_b),    int'(eb[4]));
    chk("b_done",    int'(done_b),    int'(eb[3]));
    chk("b_s_clk",   int'(s_clk_b),   int'(eb[2]));
    chk("b_s_dat",   int'(s_dat_b),   int'(eb[1]));
    chk("b_s_latch", int'(s_latch_b), int'(eb[0]));
  end

  // ---------------- monitors ----------------
  logic q_a[$];
  logic q_b[$];
  int   lat_a = 0;
  int   don_a = 0;

  always @(posedge s_clk_a) q_a.push_back(s_dat_a);
  always @(posedge s_clk_b) q_b.push_back(s_dat_b);
  always @(negedge clk) begin
    if (s_latch_a) lat_a++;
    if (done_a) don_a++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge, then count busy cycles, the done position
  // and latch cycles relative to the accept edge.
  task automatic run_frame(input bit use_b, output int busy_cyc,
                           output int done_at, output int latch_cyc);
    logic bz, dn, lt;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    start_b = 1'b0;
    busy_cyc = 0; done_at = -1; latch_cyc = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      bz = use_b ? busy_b : busy_a;
      dn = use_b ? done_b : done_a;
      lt = use_b ? s_latch_b : s_latch_a;
      if (!bz) break;
      busy_cyc++;
      if (dn) done_at = c;
      if (lt) latch_cyc++;
    end
  endtask

  function automatic logic [31:0] bits_a(input int s0);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (s0 + i < q_a.size()) r[i] = q_a[s0 + i];
    return r;
  endfunction

  task automatic wait_idle_a();
    int found;
    found = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy_a) begin found = 1; break; end
    end
    chk("wait_idle_a", found, 1);
  endtask

  int lit[32] = '{1,0,0,0,0,0,0,1, 1,1,1,1,0,0,0,0,
                  1,1,0,0,0,0,1,1, 1,0,1,0,0,1,0,1};

  initial begin
    int bc, da, lc, s0, l0, d0, found;
    rst_n = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; frame_a = '0;
    start_b = 1'b0; abort_b = 1'b0; frame_b = '0;
    #1 rst_n = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      start_a = 1'($urandom); abort_a = 1'($urandom); frame_a = $urandom;
      start_b = 1'($urandom); abort_b = 1'($urandom); frame_b = 8'($urandom);
      cycle();
    end
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    @(negedge clk);
    chk("rst_outs_a", int'({busy_a, done_a, s_clk_a, s_dat_a, s_latch_a}), 0);
    chk("rst_outs_b", int'({busy_b, done_b, s_clk_b, s_dat_b, s_latch_b}), 0);
    cycle();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_a", int'({busy_a, done_a, s_clk_a, s_dat_a, s_latch_a}), 0);

    // single frame, defaults
    frame_a = 32'hA5C3_0F81;
    s0 = q_a.size();
    run_frame(1'b0, bc, da, lc);
    chk("t1_busy_len", bc, 132);
    chk("t1_done_at", da, 132);
    chk("t1_latch_len", lc, 2);
    chk("t1_edges", q_a.size() - s0, 32);
    for (int i = 0; i < 32; i++)
      chk($sformatf("t1_bit%0d", i), int'(bits_a(s0)) >> i & 1, lit[i]);

    // minimal instance: one byte, divide by one
    frame_b = 8'hFF;
    s0 = q_b.size();
    run_frame(1'b1, bc, da, lc);
    chk("t2_busy_len", bc, 19);
    chk("t2_done_at", da, 19);
    chk("t2_latch_len", lc, 1);
    chk("t2_edges", q_b.size() - s0, 8);
    for (int i = 0; i < 8; i++)
      if (s0 + i < q_b.size()) chk($sformatf("t2_bit%0d", i), int'(q_b[s0 + i]), 1);

    // back-to-back with start held and frame changed mid-frame
    frame_a = 32'h1234_5678;
    start_a = 1'b1;
    s0 = q_a.size();
    cycle();
    repeat (20) cycle();
    frame_a = 32'hDEAD_BEEF;
    found = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (done_a) begin found = 1; break; end
    end
    chk("t3_done_seen", found, 1);
    @(negedge clk);
    chk("t3_gap_busy", int'(busy_a), 0);
    @(posedge clk);
    #1 start_a = 1'b0;
    @(negedge clk);
    chk("t3_second_busy", int'(busy_a), 1);
    chk("t3_first_frame", int'(bits_a(s0)), int'(32'h1234_5678));
    wait_idle_a();
    chk("t3_second_frame", int'(bits_a(s0 + 32)), int'(32'hDEAD_BEEF));
    chk("t3_edges", q_a.size() - s0, 64);

    // abort after the 11th rising edge
    frame_a = 32'hA5C3_0F81;
    s0 = q_a.size();
    l0 = lat_a; d0 = don_a;
    start_a = 1'b1;
    cycle();
    start_a = 1'b0;
    found = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (q_a.size() - s0 >= 11) begin found = 1; break; end
    end
    chk("t4_11_edges_seen", found, 1);
    cycle();
    abort_a = 1'b1;
    cycle();
    abort_a = 1'b0;
    @(negedge clk);
    chk("t4_idle_after_abort", int'({busy_a, s_clk_a, s_dat_a}), 0);
    repeat (40) cycle();
    chk("t4_edges", q_a.size() - s0, 11);
    chk("t4_no_latch", lat_a - l0, 0);
    chk("t4_no_done", don_a - d0, 0);
    s0 = q_a.size();
    run_frame(1'b0, bc, da, lc);
    chk("t4_restart_busy", bc, 132);
    chk("t4_restart_frame", int'(bits_a(s0)), int'(32'hA5C3_0F81));

    // start with abort in idle is blocked; start alone is accepted
    frame_a = 32'h0000_00C6;
    start_a = 1'b1; abort_a = 1'b1;
    cycle();
    abort_a = 1'b0;
    @(negedge clk);
    chk("t5_blocked_busy", int'(busy_a), 0);
    cycle();
    start_a = 1'b0;
    @(negedge clk);
    chk("t5_accepted_busy", int'(busy_a), 1);

    // async reset in the middle of a high phase
    found = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (s_clk_a) begin found = 1; break; end
    end
    chk("t6_high_seen", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_outs", int'({busy_a, done_a, s_clk_a, s_dat_a, s_latch_a}), 0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_post_outs", int'({busy_a, done_a, s_clk_a, s_dat_a, s_latch_a}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_out_ctrl.md
Name: shift_out_ctrl

Overview:
- Sequencer for an 8-bit load/shift-right register that serializes a multi-byte frame onto a 3-wire chain (s_clk, s_dat, s_latch) of external shift registers (LED/7-seg drivers on the lab board).
- Captures a parallel frame on a start handshake and drives the internal register: parallel load, then shift right with LSB out.
- Generates the divided serial clock and the final latch strobe, then reports completion.

Parameters:
- NBYTES, 4, bytes per frame (>=1); byte 0 = frame[7:0] is sent first.
- CLK_DIV, 2, clk cycles per half period of s_clk (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  synchronous cancel of a frame in progress.
- frame  input  8*NBYTES  parallel frame data, captured when start is accepted.
- busy  output  1  high from the cycle after acceptance until the return to IDLE.
- done  output  1  one-cycle pulse after the latch strobe; not asserted on abort.
- s_clk  output  1  serial clock; receiver samples s_dat on its rising edge.
- s_dat  output  1  serial data = bit 0 of the internal shift register.
- s_latch  output  1  storage-register strobe, high for CLK_DIV cycles after the last bit.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- rst_n low, async and at any time including mid-frame:
  - FSM goes to IDLE.
  - busy=0, done=0, s_clk=0, s_dat=0, s_latch=0.
  - Shift register, frame buffer and all counters cleared.
- FSM states:
  - IDLE: all outputs 0. start=1 captures frame into the buffer and goes to LOAD. start while not IDLE is ignored.
  - LOAD: 1 cycle. Shift register <= buffer byte 0; bit_cnt=0, byte_idx=0, div_cnt=0. Next state LOW.
  - LOW: s_clk=0, s_dat=sr[0], lasts CLK_DIV cycles, then HIGH.
  - HIGH: s_clk=1, lasts CLK_DIV cycles. On its last cycle:
    - bit_cnt<7: shift right with 0 into bit 7; bit_cnt++; go to LOW.
    - bit_cnt=7 and byte_idx<NBYTES-1: parallel-load byte byte_idx+1; bit_cnt=0; byte_idx++; go to LOW. There is no gap cycle between bytes.
    - bit_cnt=7 and byte_idx=NBYTES-1: go to LATCH.
  - LATCH: s_clk=0, s_latch=1, lasts CLK_DIV cycles, then DONE.
  - DONE: 1 cycle, done=1, busy=1, then IDLE.
- Bit order: within each byte LSB first; bytes in ascending index order.
- s_dat changes only on entry to LOW, so it is stable for the whole HIGH phase.
- Latency: busy rises 1 cycle after the start-accept edge. busy lasts 1 + 16*NBYTES*CLK_DIV + CLK_DIV + 1 cycles (132 at defaults).
- abort=1 in LOAD, LOW or HIGH:
  - Next cycle is IDLE; s_clk=0 and s_dat=0.
  - No latch strobe and no done pulse.
  - abort in LATCH or DONE is ignored, so the frame completes.
  - abort in IDLE has no effect and blocks a simultaneous start (abort has priority).
- start and done in the same cycle: start is not accepted in DONE. It is accepted the next cycle if it is still high in IDLE.
- Counters: div_cnt is ceil(log2(CLK_DIV)) bits wide with a minimum of 1; bit_cnt is 3 bits; byte_idx is ceil(log2(NBYTES)) bits wide with a minimum of 1. None of the counters wrap during a valid frame.
- The frame buffer is not updated while busy; changes on the frame input after acceptance have no effect.

Test Plan:
- Reset defaults: hold rst_n=0 with random inputs, then release → all outputs 0, FSM in IDLE. Assert rst_n=0 mid-HIGH → outputs 0 asynchronously, before the next clk edge.
- Single frame, defaults, frame=32'hA5C3_0F81 → s_dat sampled on s_clk rising edges = 1,0,0,0,0,0,0,1 then 1,1,1,1,0,0,0,0 then 1,1,0,0,0,0,1,1 then 1,0,1,0,0,1,0,1. Also: 32 rising edges; s_latch high 2 cycles; done pulse at cycle 132 after acceptance; busy high exactly 132 cycles.
- CLK_DIV=1, NBYTES=1, frame=8'hFF → s_clk toggles every cycle (8 periods), s_dat=1 throughout; busy high 1+16+1+1=19 cycles.
- Back-to-back: hold start high continuously with frame changed mid-frame → first frame's bits are unaffected. Second frame is accepted in the IDLE cycle right after DONE, and its busy rises 1 cycle later.
- Abort after the 11th rising edge of s_clk → IDLE on the next cycle; no s_latch pulse; no done pulse. A following start sends the full frame from byte 0.
- start and abort asserted together in IDLE → not accepted, busy stays 0. start alone on the next cycle → accepted.
